// File: rtl/rst_seq_if.sv
// Reset-sequencer signal bundle: soft reset request and IMU ready flow into
// the sequencer; the three domain resets and status flags flow out of it.
interface rst_seq_if;
    logic soft_rst_req;
    logic imu_rdy;
    logic rst_imu_n;
    logic rst_ctrl_n;
    logic rst_pwm_n;
    logic sys_rdy;
    logic seq_fault;

    // Controller side (system / fault handler / testbench)
    modport master (
        output soft_rst_req,
        output imu_rdy,
        input  rst_imu_n,
        input  rst_ctrl_n,
        input  rst_pwm_n,
        input  sys_rdy,
        input  seq_fault
    );

    // Sequencer side
    modport slave (
        input  soft_rst_req,
        input  imu_rdy,
        output rst_imu_n,
        output rst_ctrl_n,
        output rst_pwm_n,
        output sys_rdy,
        output seq_fault
    );
endinterface

// File: rtl/rst_seq.sv
// Segway reset sequencer: releases IMU/SPI, then balance control, then
// PWM/motor drive, holding motors in reset until sensing and control are up.
// A soft reset request or loss of the IMU re-runs the whole sequence.
module rst_seq #(
    parameter int HOLD_CYC    = 16,
    parameter int STAGE_GAP   = 8,
    parameter int ACK_TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     RST_n,
    rst_seq_if.slave sif
);

    localparam int MAX_A = (HOLD_CYC > STAGE_GAP) ? HOLD_CYC : STAGE_GAP;
    localparam int MAX_C = (MAX_A > ACK_TIMEOUT) ? MAX_A : ACK_TIMEOUT;
    localparam int CNT_W = $clog2(MAX_C + 1);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_HOLD,
        S_REL_IMU,
        S_GAP_CTRL,
        S_GAP_PWM,
        S_RUN,
        S_FAULT
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    // Number of domains released in a state; domain gi is out of reset
    // when rank > gi, which makes out-of-order release impossible.
    logic [1:0] rank_next;
    logic [2:0] rst_n_next;
    logic [2:0] rst_n_reg;
    logic       sys_rdy_reg, sys_rdy_next;
    logic       seq_fault_reg, seq_fault_next;

    // Next-state selection; soft reset overrides every other transition
    always_comb begin
        state_next = state_reg;
        if (sif.soft_rst_req) begin
            state_next = S_HOLD;
        end else begin
            case (state_reg)
                S_HOLD:     if (cnt_reg == HOLD_LAST) state_next = S_REL_IMU;
                S_REL_IMU: begin
                    // A late ack on the timeout cycle still counts as success
                    if (sif.imu_rdy)              state_next = S_GAP_CTRL;
                    else if (cnt_reg == ACK_LAST) state_next = S_FAULT;
                end
                S_GAP_CTRL: if (cnt_reg == GAP_LAST) state_next = S_GAP_PWM;
                S_GAP_PWM:  if (cnt_reg == GAP_LAST) state_next = S_RUN;
                S_RUN:      if (!sif.imu_rdy)        state_next = S_HOLD;
                S_FAULT:    state_next = S_FAULT;
                default:    state_next = S_HOLD;
            endcase
        end
    end

    // Counter restarts on any state change; a held soft request is treated
    // as continual re-entry to HOLD so the full hold time follows its release.
    always_comb begin
        if (sif.soft_rst_req || (state_next != state_reg)) begin
            cnt_next = '0;
        end else if (cnt_reg != {CNT_W{1'b1}}) begin
            cnt_next = cnt_reg + 1'b1;
        end else begin
            cnt_next = cnt_reg;
        end
    end

    // Output decode from the next state so outputs move on the state edge
    always_comb begin
        rank_next      = 2'd0;
        sys_rdy_next   = 1'b0;
        seq_fault_next = 1'b0;
        case (state_next)
            S_HOLD:     rank_next = 2'd0;
            S_REL_IMU:  rank_next = 2'd1;
            S_GAP_CTRL: rank_next = 2'd1;
            S_GAP_PWM:  rank_next = 2'd2;
            S_RUN: begin
                rank_next    = 2'd3;
                sys_rdy_next = 1'b1;
            end
            S_FAULT: begin
                rank_next      = 2'd1;
                seq_fault_next = 1'b1;
            end
            default:    rank_next = 2'd0;
        endcase
    end

    // Per-domain release: index 0 = IMU, 1 = ctrl, 2 = pwm
    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_dom
            assign rst_n_next[gi] = (rank_next > 2'(gi));
        end
    endgenerate

    // State, counter and registered outputs; RST_n forces reset values at once
    always_ff @(posedge clk or negedge RST_n) begin
        if (!RST_n) begin
            state_reg     <= S_HOLD;
            cnt_reg       <= '0;
            rst_n_reg     <= 3'b000;
            sys_rdy_reg   <= 1'b0;
            seq_fault_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rst_n_reg     <= rst_n_next;
            sys_rdy_reg   <= sys_rdy_next;
            seq_fault_reg <= seq_fault_next;
        end
    end

    assign sif.rst_imu_n  = rst_n_reg[0];
    assign sif.rst_ctrl_n = rst_n_reg[1];
    assign sif.rst_pwm_n  = rst_n_reg[2];
    assign sif.sys_rdy    = sys_rdy_reg;
    assign sif.seq_fault  = seq_fault_reg;

endmodule
